// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with
// memory wait timeout, halt at instruction boundaries and a retired-instruction
// counter.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start (ignored while err is set)
//   FETCH  | instruction memory request; ir_load on mem_ack
//   DECODE | latch control word and opclass; unknown opclass retires as NOP
//   EXEC   | drive alu_op; branches retire here
//   MEM    | data memory request, write enable from latched MemWrite
//   WB     | register-file write and retire
module multicycle_sequencer #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic [2:0]  opclass,
  input  logic [31:0] ctrl_word,
  input  logic        mem_ack,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [3:0]  alu_op,
  output logic [2:0]  state,
  output logic        busy,
  output logic        err,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] OPC_RTYPE  = 3'b010;
  localparam logic [2:0] OPC_BRANCH = 3'b100;
  localparam logic [2:0] OPC_ITYPE  = 3'b110;
  localparam logic [2:0] OPC_MEMORY = 3'b111;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_aluop;
  logic        r_memwrite;
  logic        r_rfwrite;
  logic [2:0]  r_opclass;
  logic [7:0]  r_wait;
  logic        r_err;
  logic [15:0] r_instr_count;

  logic        w_waiting;
  logic        w_timeout;
  logic        w_valid_opc;
  state_t      w_retire_dest;
  logic        w_unused_ctrl;

  // ALU source selects and WBDSelect are consumed by the datapath, not here
  assign w_unused_ctrl = ^{ctrl_word[27:22], ctrl_word[20], ctrl_word[18:0]};

  assign w_waiting     = (r_state == S_FETCH) || (r_state == S_MEM);
  // an ack arriving in the timeout cycle wins
  assign w_timeout     = w_waiting && !mem_ack && (r_wait == MEM_TIMEOUT - 8'd1);
  assign w_valid_opc   = (opclass == OPC_RTYPE) || (opclass == OPC_BRANCH) ||
                         (opclass == OPC_ITYPE) || (opclass == OPC_MEMORY);
  // halt only matters when the next instruction would be fetched
  assign w_retire_dest = halt ? S_IDLE : S_FETCH;

  assign state       = r_state;
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign alu_op      = r_aluop;
  assign instr_count = r_instr_count;

  // Next-state and control outputs
  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
    rf_we   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !halt && !r_err) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = !w_timeout;
        if (mem_ack) begin
          ir_load = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_DECODE: begin
        if (w_valid_opc) begin
          w_next = S_EXEC;
        end else begin
          pc_en  = 1'b1;
          w_next = w_retire_dest;
        end
      end
      S_EXEC: begin
        if (r_opclass == OPC_BRANCH) begin
          pc_en  = 1'b1;
          pc_sel = branch_taken;
          w_next = w_retire_dest;
        end else if (r_opclass == OPC_MEMORY) begin
          w_next = S_MEM;
        end else if (r_rfwrite) begin
          w_next = S_WB;
        end else begin
          pc_en  = 1'b1;
          w_next = w_retire_dest;
        end
      end
      S_MEM: begin
        mem_req = !w_timeout;
        mem_we  = r_memwrite && !w_timeout;
        if (mem_ack) begin
          if (r_rfwrite) begin
            w_next = S_WB;
          end else begin
            pc_en  = 1'b1;
            w_next = w_retire_dest;
          end
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_en  = 1'b1;
        w_next = w_retire_dest;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Capture the decoded control fields for EXEC/MEM/WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluop    <= 4'd0;
      r_memwrite <= 1'b0;
      r_rfwrite  <= 1'b0;
      r_opclass  <= 3'd0;
    end else if (r_state == S_DECODE) begin
      r_aluop    <= ctrl_word[31:28];
      r_memwrite <= ctrl_word[21];
      r_rfwrite  <= ctrl_word[19];
      r_opclass  <= opclass;
    end
  end

  // Memory wait counter: cleared on entry to FETCH/MEM, counts unacked cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= 8'd0;
    end else if (((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state)) begin
      r_wait <= 8'd0;
    end else if (w_waiting && !mem_ack) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  // Retired instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_instr_count <= 16'd0;
    else if (pc_en) r_instr_count <= r_instr_count + 16'd1;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have the parameter MEM_TIMEOUT, default 8'd255, giving the maximum number of cycles to wait for mem_ack.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: leave IDLE and begin fetching.
REQ-005 The block SHALL have the port halt, input, 1 bit: stop at the next instruction boundary.
REQ-006 The block SHALL have the port opclass, input, 3 bits: instruction[31:29], where 010=RTYPE, 100=BRANCH, 110=ITYPE, 111=MEMORY.
REQ-007 The block SHALL have the port ctrl_word, input, 32 bits: the decoded control word, with aluop[31:28], ALUSrcA[27:25], ALUSrcB[24:22], MemWrite[21], WBDSelect[20], RegFileWrite[19].
REQ-008 The block SHALL have the port mem_ack, input, 1 bit: memory completes the current request this cycle.
REQ-009 The block SHALL have the port branch_taken, input, 1 bit: branch condition from the ALU, valid in EXEC.
REQ-010 The block SHALL have the ports mem_req and mem_we, outputs, 1 bit each: memory request and write enable.
REQ-011 The block SHALL have the ports ir_load, pc_en, pc_sel and rf_we, outputs, 1 bit each: IR load, PC update, PC source (1 = branch target) and register-file write.
REQ-012 The block SHALL have the port alu_op, output, 4 bits: the latched aluop.
REQ-013 The block SHALL have the ports state, output, 3 bits, and busy, output, 1 bit.
REQ-014 The block SHALL have the port err, output, 1 bit: sticky memory-timeout flag.
REQ-015 The block SHALL have the port instr_count, output, 16 bits: count of retired instructions.

Function
REQ-016 State encoding SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-017 IDLE SHALL go to FETCH when start=1 and halt=0, and SHALL otherwise stay in IDLE.
REQ-018 FETCH SHALL assert mem_req=1 and mem_we=0; on mem_ack it SHALL pulse ir_load for that same cycle (combinational from mem_ack) and go to DECODE.
REQ-019 DECODE SHALL take exactly 1 cycle and SHALL latch ctrl_word and opclass into internal registers.
REQ-020 In DECODE, an opclass not in {010,100,110,111} SHALL be treated as a NOP: pulse pc_en and go to FETCH.
REQ-021 In DECODE, any valid opclass SHALL go to EXEC.
REQ-022 EXEC SHALL drive alu_op from the latched aluop; all other cycles SHALL hold alu_op at its last latched value.
REQ-023 EXEC with BRANCH SHALL pulse pc_en, set pc_sel=branch_taken and go to FETCH.
REQ-024 EXEC with MEMORY SHALL go to MEM.
REQ-025 EXEC with RTYPE or ITYPE SHALL go to WB when the latched RegFileWrite=1, and otherwise SHALL pulse pc_en and go to FETCH.
REQ-026 MEM SHALL assert mem_req=1 and mem_we equal to the latched MemWrite.
REQ-027 On mem_ack in MEM, the block SHALL go to WB when the latched RegFileWrite=1, and otherwise SHALL pulse pc_en and go to FETCH.
REQ-028 WB SHALL assert rf_we=1 and pc_en=1 for exactly one cycle, then go to FETCH.
REQ-029 halt SHALL be sampled only on a transition into FETCH; if halt=1 the block SHALL go to IDLE instead, with the retiring pc_en still issued.
REQ-030 Every pc_en pulse SHALL increment instr_count by 1, wrapping from 0xFFFF to 0x0000.
REQ-031 A wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle there without mem_ack.
REQ-032 When the wait counter reaches MEM_TIMEOUT, the block SHALL set err=1, drop mem_req, and go to IDLE.
REQ-033 err SHALL be cleared only by rst.
REQ-034 While err=1, start SHALL be ignored.
REQ-035 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-036 mem_ack on the same cycle the timeout is reached SHALL take priority, with no error.
REQ-037 busy SHALL be 1 in every state except IDLE.
REQ-038 pc_sel SHALL be 0 except during the EXEC cycle of a BRANCH.

Reset
REQ-039 On rst=1, state SHALL become IDLE immediately, independent of clk.
REQ-040 On rst=1, these outputs SHALL be 0: mem_req, mem_we, ir_load, pc_en, pc_sel, rf_we, busy, err, alu_op, instr_count, and the wait counter.
REQ-041 An rst asserted mid-request SHALL drop mem_req in the same cycle.
REQ-042 After rst is released, the block SHALL wait in IDLE for start.

Verification
REQ-043 RTYPE ADD, ctrl_word=0x1008_0000, mem_ack on the first FETCH cycle -> states 1,2,3,5,1; rf_we pulses once; instr_count=1.
REQ-044 MEMORY SW, ctrl_word[21]=1, mem_ack delayed 3 cycles in MEM -> mem_req and mem_we high for 4 cycles; rf_we=0; pc_en pulses once.
REQ-045 BRANCH with branch_taken=1 -> pc_sel=1 and pc_en=1 in the same EXEC cycle; next state FETCH; rf_we never asserted.
REQ-046 Withhold mem_ack in FETCH for 255 cycles -> err=1 and state=IDLE; a later start pulse leaves state at IDLE.
REQ-047 Preload instr_count=0xFFFF and retire one instruction -> instr_count=0x0000.
REQ-048 Assert halt during EXEC of an ITYPE with RegFileWrite=1 -> WB completes, then state=IDLE with busy=0.
REQ-049 Assert rst in MEM while mem_req=1 -> state=0 and mem_req=0 before the next clk edge.
